// File: rtl/mac_psum_drain.sv
// mac_psum_drain: snapshots the four MAC partial sums on the falling edge of
// Block_control, then streams them out in bank order 0..3, one word per
// handshake. Each word is right-shifted and then saturated to OUT_WIDTH bits.
//
// Handshake: a word transfers on a rising Clk edge where Out_valid and
// Out_ready are both high. Out_valid, Out_data, Out_index and Out_last come
// only from registered state, so they never depend combinationally on
// Out_ready. While Out_ready is low they hold stable.
module mac_psum_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 4 * DATA_WIDTH,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 0
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  Block_control,
    input  logic [PSUM_WIDTH-1:0] Psum_0,
    input  logic [PSUM_WIDTH-1:0] Psum_1,
    input  logic [PSUM_WIDTH-1:0] Psum_2,
    input  logic [PSUM_WIDTH-1:0] Psum_3,
    output logic [OUT_WIDTH-1:0]  Out_data,
    output logic [1:0]            Out_index,
    output logic                  Out_last,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic                  Busy,
    output logic                  Overrun,
    input  logic                  Clear_overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [PSUM_WIDTH-1:0] SAT_MAX =
        {{(PSUM_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic [0:0]            state;
    logic                  bc_d;
    logic [1:0]            idx;
    logic [PSUM_WIDTH-1:0] bank_q [4];

    logic                  block_end;
    logic                  sending;
    logic                  final_xfer;
    logic                  capture;
    logic                  drop;
    logic [PSUM_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]  sat_word;

    // The MAC clears its banks on the same edge where Block_control first goes
    // low. That cycle is therefore the only chance to grab Psum_*.
    assign block_end  = bc_d & ~Block_control;
    assign sending    = (state == ST_SEND);
    assign final_xfer = sending & Out_ready & (idx == 2'd3);
    assign capture    = block_end & (~sending | final_xfer);
    assign drop       = block_end & ~capture;

    // Shift and saturate the bank selected by idx.
    always_comb begin
        shifted  = bank_q[idx] >> SHIFT;
        sat_word = (shifted > SAT_MAX) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
    end

    // Output stage: driven only from state, idx and the buffered banks.
    always_comb begin
        Busy      = sending;
        Out_valid = sending;
        Out_index = sending ? idx : 2'd0;
        Out_last  = sending & (idx == 2'd3);
        Out_data  = sending ? sat_word : '0;
    end

    // Edge detector delay on Block_control.
    always_ff @(posedge Clk) begin
        if (!rst) bc_d <= 1'b0;
        else      bc_d <= Block_control;
    end

    // Stream FSM. A capture on the last handshake of a stream chains straight
    // into the next stream, so back-to-back blocks leave no idle gap.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= 2'd0;
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
        end else if (capture) begin
            state     <= ST_SEND;
            idx       <= 2'd0;
            bank_q[0] <= Psum_0;
            bank_q[1] <= Psum_1;
            bank_q[2] <= Psum_2;
            bank_q[3] <= Psum_3;
        end else if (sending && Out_ready) begin
            if (idx == 2'd3) state <= ST_IDLE;
            else             idx   <= idx + 2'd1;
        end
    end

    // Sticky overrun flag. When a block end is dropped in the same cycle as a
    // clear request, the set wins.
    always_ff @(posedge Clk) begin
        if (!rst)               Overrun <= 1'b0;
        else if (drop)          Overrun <= 1'b1;
        else if (Clear_overrun) Overrun <= 1'b0;
    end

endmodule

// File: doc/mac_psum_drain.md
Name: mac_psum_drain

Overview:
Reader at the far end of the MAC unit's partial-sum interface. It detects the end of an accumulation block on Block_control and snapshots the four exposed partial sums. It then streams them out one word per handshake, in bank order 0..3, after a right-shift and unsigned saturation. It sits between each MAC unit and the output buffer/writeback path, and is driven by the same Block_control the controller sends to the MAC.

Parameters:
DATA_WIDTH, 8, MAC operand width
PSUM_WIDTH, 4*DATA_WIDTH, partial-sum width (32 by default)
OUT_WIDTH, 8, width of each streamed output word
SHIFT, 0, right-shift (0..PSUM_WIDTH-1) applied before saturation

Ports:
Clk  in  1  clock
rst  in  1  synchronous, active-low reset
Block_control  in  1  1 = MAC accumulating; 0 = partial sums exposed on Psum_*
Psum_0  in  PSUM_WIDTH  partial sum bank 0 (unsigned)
Psum_1  in  PSUM_WIDTH  partial sum bank 1
Psum_2  in  PSUM_WIDTH  partial sum bank 2
Psum_3  in  PSUM_WIDTH  partial sum bank 3
Out_data  out  OUT_WIDTH  processed partial sum
Out_index  out  2  bank index of Out_data
Out_last  out  1  high with Out_valid when Out_index==3
Out_valid  out  1  Out_data valid
Out_ready  in  1  downstream accepts
Busy  out  1  high in SEND
Overrun  out  1  sticky: a block end was dropped
Clear_overrun  in  1  clears Overrun

Behaviour:
- Reset is rst==0 at posedge Clk, synchronous. Reset clears: state=IDLE, bc_d=0, idx=0, buffers=0, Overrun=0. All outputs read 0 during and after reset until the first capture.
- Edge detect: bc_d <= Block_control every cycle. block_end = bc_d & ~Block_control. block_end is the first cycle Block_control is low. This is the only cycle Psum_* are valid, because the MAC clears its banks at this posedge.
- Capture condition: block_end AND (state==IDLE OR final handshake this cycle). On capture at posedge: buf[0..3] <= Psum_0..3; idx <= 0; state <= SEND.
- Dropped capture: block_end in any other cycle is discarded, Overrun <= 1, and the stream in progress continues unaffected.
- Overrun priority: Clear_overrun clears Overrun; a set in the same cycle wins.
- SEND state:
  - Out_valid=1; Out_index=idx; Out_last=(idx==3); Out_data=sat(buf[idx]).
  - Outputs are registered-source: they depend only on state, idx and buf, never combinationally on Out_ready.
  - Out_data, Out_index and Out_last must hold stable while Out_valid=1 and Out_ready=0.
- Handshake: transfer when Out_valid & Out_ready at posedge. idx<3: idx <= idx+1. idx==3: state <= IDLE unless a capture occurs that cycle, in which case state stays SEND with idx <= 0 and new buffers.
- IDLE state: Out_valid=0, Out_last=0, Busy=0. Out_data and Out_index = 0.
- Arithmetic: s = buf >> SHIFT (logical, unsigned). sat = (s > 2^OUT_WIDTH-1) ? 2^OUT_WIDTH-1 : s[OUT_WIDTH-1:0].
- Throughput: minimum 4 cycles per block with Out_ready held high. First Out_valid is 1 cycle after block_end.
- Block_control low for many cycles produces exactly one capture, since only the falling edge counts.
- Block_control low out of reset (bc_d=0) produces no capture.
- Reset mid-SEND: the stream is aborted and Out_valid=0 the next cycle; buffered data is lost; no Overrun is set.

Test Plan:
- SHIFT=0, OUT_WIDTH=8, Out_ready=1; Block_control 1->0 with Psum=5,300,255,0 -> next 4 cycles Out_data=5,255,255,0; Out_index=0..3; Out_last only on the 4th; Busy=1 for exactly 4 cycles.
- Backpressure: same data, Out_ready toggles 0,0,1,0,1,1,0,1 -> every word held stable while stalled; order 0..3 preserved; exactly 4 transfers.
- SHIFT=4: Psum_0=0x1230 -> Out_data=0xFF. Psum_1=0x00F0 -> 0x0F.
- Overrun: second block_end while idx=1 -> Overrun=1; the original 4 words complete unchanged; no second stream. Clear_overrun -> Overrun=0 next cycle.
- Back-to-back: block_end coincides with the idx==3 handshake -> new stream starts with idx=0 next cycle with new values; Overrun stays 0.
- Reset: rst=0 during idx=2 with Out_ready=0 -> Out_valid=0 and Busy=0 next cycle. Block_control held 0 after reset -> no capture.
